// File: rtl/axis_eth_rx_mac_filter_if.sv
// AXI4-Stream bundle used on both sides of the RX MAC filter.
interface axis_eth_rx_mac_filter_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_eth_rx_mac_filter.sv
// Destination-MAC filter: holds the first two words of a frame, decides
// accept/drop from the destination address, then replays or discards the frame.
module axis_eth_rx_mac_filter #(
  parameter int unsigned STATS_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [47:0]                our_mac,
  input  logic                       promisc,
  input  logic                       allow_mcast,
  input  logic                       count_clear,
  axis_eth_rx_mac_filter_if.slave    s,
  axis_eth_rx_mac_filter_if.master   m,
  output logic [STATS_WIDTH-1:0]     accept_count,
  output logic [STATS_WIDTH-1:0]     drop_count,
  output logic [STATS_WIDTH-1:0]     runt_count
);

  localparam logic [2:0] HDR0    = 3'd0;
  localparam logic [2:0] HDR1    = 3'd1;
  localparam logic [2:0] REPLAY0 = 3'd2;
  localparam logic [2:0] REPLAY1 = 3'd3;
  localparam logic [2:0] PASS    = 3'd4;
  localparam logic [2:0] DROP    = 3'd5;

  logic [2:0]             r_state;
  logic [31:0]            r_w0_data, r_w1_data;
  logic [3:0]             r_w0_keep, r_w1_keep;
  logic                   r_w0_user, r_w1_user, r_w1_last;
  logic [STATS_WIDTH-1:0] r_acc, r_drop, r_runt;

  logic        w_s_fire, w_m_fire, w_runt, w_accept;
  logic        w_inc_acc, w_inc_drop, w_inc_runt;
  logic [47:0] w_dst;

  assign w_s_fire = s.tvalid && s.tready;
  assign w_m_fire = m.tvalid && m.tready;

  // Word1 is still on the input bus at the decision cycle, so its bytes come live.
  assign w_dst = {r_w0_data[7:0], r_w0_data[15:8], r_w0_data[23:16], r_w0_data[31:24],
                  s.tdata[7:0], s.tdata[15:8]};
  assign w_runt   = s.tlast && (s.tkeep != 4'b1111);
  assign w_accept = promisc || (w_dst == our_mac) || (&w_dst) || (allow_mcast && w_dst[40]);

  assign w_inc_runt = w_s_fire && (((r_state == HDR0) && s.tlast) || ((r_state == HDR1) && w_runt));
  assign w_inc_acc  = w_s_fire && (r_state == HDR1) && !w_runt && w_accept;
  assign w_inc_drop = w_s_fire && (r_state == HDR1) && !w_runt && !w_accept;

  always_comb begin
    s.tready = 1'b0;
    m.tvalid = 1'b0;
    m.tdata  = r_w0_data;
    m.tkeep  = r_w0_keep;
    m.tlast  = 1'b0;
    m.tuser  = r_w0_user;
    if (!rst) begin
      case (r_state)
        HDR0, HDR1, DROP: s.tready = 1'b1;
        REPLAY0:          m.tvalid = 1'b1;
        REPLAY1: begin
          m.tvalid = 1'b1;
          m.tdata  = r_w1_data;
          m.tkeep  = r_w1_keep;
          m.tlast  = r_w1_last;
          m.tuser  = r_w1_user;
        end
        PASS: begin
          m.tvalid = s.tvalid;
          s.tready = m.tready;
          m.tdata  = s.tdata;
          m.tkeep  = s.tkeep;
          m.tlast  = s.tlast;
          m.tuser  = s.tuser;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR0;
    end else begin
      case (r_state)
        HDR0:    if (w_s_fire && !s.tlast) r_state <= HDR1;
        HDR1: begin
          if (w_s_fire) begin
            if (w_runt)        r_state <= HDR0;
            else if (w_accept) r_state <= REPLAY0;
            else if (s.tlast)  r_state <= HDR0;
            else               r_state <= DROP;
          end
        end
        REPLAY0: if (w_m_fire) r_state <= REPLAY1;
        REPLAY1: if (w_m_fire) r_state <= r_w1_last ? HDR0 : PASS;
        PASS:    if (w_s_fire && s.tlast) r_state <= HDR0;
        DROP:    if (w_s_fire && s.tlast) r_state <= HDR0;
        default: r_state <= HDR0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_fire && (r_state == HDR0)) begin
      r_w0_data <= s.tdata;
      r_w0_keep <= s.tkeep;
      r_w0_user <= s.tuser;
    end
    if (w_s_fire && (r_state == HDR1)) begin
      r_w1_data <= s.tdata;
      r_w1_keep <= s.tkeep;
      r_w1_user <= s.tuser;
      r_w1_last <= s.tlast;
    end
  end

  function automatic logic [STATS_WIDTH-1:0] f_bump(input logic [STATS_WIDTH-1:0] c,
                                                   input logic inc);
    return (inc && !(&c)) ? c + STATS_WIDTH'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || count_clear) begin
      r_acc  <= '0;
      r_drop <= '0;
      r_runt <= '0;
    end else begin
      r_acc  <= f_bump(r_acc, w_inc_acc);
      r_drop <= f_bump(r_drop, w_inc_drop);
      r_runt <= f_bump(r_runt, w_inc_runt);
    end
  end

  assign accept_count = r_acc;
  assign drop_count   = r_drop;
  assign runt_count   = r_runt;

endmodule

// File: tb/tb_axis_eth_rx_mac_filter.sv
// Directed bench for the RX MAC filter: byte-level frame model plus per-cycle output monitor.
module tb_axis_eth_rx_mac_filter;
  localparam int unsigned SW  = 3;
  localparam int          SAT = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [47:0]   our_mac;
  logic          promisc, allow_mcast, count_clear;
  logic [SW-1:0] accept_count, drop_count, runt_count;

  axis_eth_rx_mac_filter_if s_if ();
  axis_eth_rx_mac_filter_if m_if ();

  axis_eth_rx_mac_filter #(.STATS_WIDTH(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .our_mac      (our_mac),
    .promisc      (promisc),
    .allow_mcast  (allow_mcast),
    .count_clear  (count_clear),
    .s            (s_if.slave),
    .m            (m_if.master),
    .accept_count (accept_count),
    .drop_count   (drop_count),
    .runt_count   (runt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t      exp_q[$];
  bit         dec_q[$];
  int         total = 0;
  int         bad = 0;
  int         m_acc = 0, m_drop = 0, m_runt = 0;
  int         tr_mode = 0;
  logic [7:0] fb [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < SAT) ? x + 1 : x;
  endfunction

  // 0 = runt, 1 = accept, 2 = address drop
  function automatic int classify(input int len);
    logic [47:0] d;
    if (len < 8) return 0;
    d = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    if (promisc || (d == our_mac) || (d == 48'hffff_ffff_ffff) || (allow_mcast && fb[0][0]))
      return 1;
    return 2;
  endfunction

  task automatic build(input logic [47:0] dst, input int len);
    for (int k = 0; k < 256; k++) fb[k] = 8'(k * 7 + len + 3);
    for (int k = 0; k < 6; k++) fb[k] = dst[47 - 8*k -: 8];
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_accept"}, accept_count, m_acc);
    chk({tag, "_drop"},   drop_count,   m_drop);
    chk({tag, "_runt"},   runt_count,   m_runt);
  endtask

  task automatic send_frame(input int len, input bit usr, input int abort_at, input bit clr_w1);
    int    nb, cls, stalls, waits;
    bit    hs;
    beat_t b;
    nb = (len + 3) / 4;
    cls = classify(len);
    stalls = 0;
    if (nb >= 2) dec_q.push_back(cls == 1);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_acc = 0; m_drop = 0; m_runt = 0;
        return;
      end
      b.d = '0;
      b.k = '0;
      for (int n = 0; n < 4; n++)
        if (4*i + n < len) begin
          b.d[8*n +: 8] = fb[4*i + n];
          b.k[n] = 1'b1;
        end
      b.l = (i == nb - 1);
      b.u = usr ^ i[0];
      if (cls == 1) exp_q.push_back(b);
      s_if.tvalid = 1'b1;
      s_if.tdata  = b.d;
      s_if.tkeep  = b.k;
      s_if.tlast  = b.l;
      s_if.tuser  = b.u;
      count_clear = clr_w1 && (i == 1);
      waits = 0;
      forever begin
        @(negedge clk);
        hs = s_if.tvalid && s_if.tready;
        @(posedge clk); #1;
        if (hs) break;
        stalls++;
        waits++;
        if (waits > 200) begin
          chk("s_handshake_timeout", waits, 0);
          s_if.tvalid = 1'b0;
          count_clear = 1'b0;
          return;
        end
      end
      count_clear = 1'b0;
    end
    s_if.tvalid = 1'b0;
    if (tr_mode == 0) chk("input_stalls", stalls, (cls == 1 && nb > 2) ? 2 : 0);
    if (cls == 0)      m_runt = sat(m_runt);
    else if (cls == 1) m_acc  = sat(m_acc);
    else               m_drop = sat(m_drop);
    if (clr_w1) begin m_acc = 0; m_drop = 0; m_runt = 0; end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = (tr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: expected-beat scoreboard, stall stability and decision latency.
  initial begin
    bit    lat_arm, lat_exp, pstall;
    int    sbeat;
    beat_t cur, pb, e;
    lat_arm = 0; lat_exp = 0; pstall = 0; sbeat = 0; pb = '0;
    forever begin
      @(negedge clk);
      cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
      if (rst) begin
        exp_q.delete();
        dec_q.delete();
        sbeat = 0; lat_arm = 0; pstall = 0;
      end else begin
        if (lat_arm) begin
          chk("first_out_latency", m_if.tvalid, lat_exp);
          lat_arm = 0;
        end
        if (pstall) begin
          chk("stall_valid_held", m_if.tvalid, 1);
          chk("stall_payload_held", cur, pb);
        end
        if (m_if.tvalid && m_if.tready) begin
          chk("out_beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_beat", cur, e);
          end
        end
        pstall = m_if.tvalid && !m_if.tready;
        pb = cur;
        if (s_if.tvalid && s_if.tready) begin
          if (sbeat == 1) begin
            lat_arm = 1;
            lat_exp = (dec_q.size() != 0) ? dec_q.pop_front() : 1'b0;
          end
          sbeat = s_if.tlast ? 0 : sbeat + 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [47:0] dsts [0:3];
    rst = 1'b1; our_mac = 48'h02_00_00_00_00_01; promisc = 1'b0; allow_mcast = 1'b0;
    count_clear = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_accept", accept_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_runt", runt_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_tready", s_if.tready, 1);
    @(posedge clk); #1;

    build(48'h02_00_00_00_00_01, 64); send_frame(64, 1'b0, -1, 1'b0); drain();
    chk("unicast_accept", accept_count, 1);

    build(48'h02_00_00_00_00_02, 64); send_frame(64, 1'b1, -1, 1'b0); drain();
    chk("other_drop", drop_count, 1);
    promisc = 1'b1;
    send_frame(64, 1'b0, -1, 1'b0); drain();
    chk("promisc_accept", accept_count, 2);
    promisc = 1'b0;

    build(48'hff_ff_ff_ff_ff_ff, 20); send_frame(20, 1'b1, -1, 1'b0); drain();
    build(48'h01_00_5e_00_00_01, 16); send_frame(16, 1'b0, -1, 1'b0); drain();
    chk("mcast_blocked", drop_count, 2);
    allow_mcast = 1'b1;
    send_frame(16, 1'b1, -1, 1'b0); drain();
    chk("mcast_allowed", accept_count, 4);
    allow_mcast = 1'b0;

    build(48'h02_00_00_00_00_01, 3); send_frame(3, 1'b0, -1, 1'b0); drain();
    build(48'h02_00_00_00_00_01, 6); send_frame(6, 1'b1, -1, 1'b0); drain();
    chk("runts", runt_count, 2);
    build(48'h02_00_00_00_00_01, 8); send_frame(8, 1'b1, -1, 1'b0); drain();
    chk("eight_byte_accept", accept_count, 5);
    check_counters("directed");

    dsts[0] = 48'h02_00_00_00_00_01; dsts[1] = 48'h02_00_00_00_00_02;
    dsts[2] = 48'hff_ff_ff_ff_ff_ff; dsts[3] = 48'h01_00_5e_00_00_07;
    tr_mode = 1;
    for (int f = 0; f < 20; f++) begin
      allow_mcast = f[0];
      build(dsts[$urandom_range(0, 3)], int'($urandom_range(1, 40)));
      send_frame(int'($urandom_range(1, 40)) | 0, 1'($urandom_range(0, 1)), -1, 1'b0);
    end
    drain();
    tr_mode = 0;
    allow_mcast = 1'b0;
    check_counters("random");

    build(48'h02_00_00_00_00_01, 64); send_frame(64, 1'b0, 5, 1'b0);
    @(negedge clk);
    chk("post_rst_m_tvalid", m_if.tvalid, 0);
    chk("post_rst_accept", accept_count, 0);
    chk("post_rst_drop", drop_count, 0);
    chk("post_rst_runt", runt_count, 0);
    @(posedge clk); #1;
    build(48'h02_00_00_00_00_09, 12); send_frame(12, 1'b0, -1, 1'b0); drain();
    build(48'h02_00_00_00_00_01, 12); send_frame(12, 1'b1, -1, 1'b0); drain();
    chk("clean_after_rst_accept", accept_count, 1);
    chk("clean_after_rst_drop", drop_count, 1);

    build(48'h02_00_00_00_00_01, 8); send_frame(8, 1'b1, -1, 1'b1); drain();
    chk("clear_beats_accept", accept_count, 0);
    check_counters("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
